// File: rtl/tlp_tx_scheduler.sv
// rtl/tlp_tx_scheduler.sv - round-robin, credit-gated scheduler merging AW/AR headers and write payload into one TLP stream
`timescale 1ns/1ps
module tlp_tx_scheduler #(
    parameter int CREDIT_WIDTH = 12,
    parameter int INIT_PH      = 32,
    parameter int INIT_PD      = 256,
    parameter int INIT_NPH     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         aw_hdr_empty,
    output logic         aw_hdr_rden,
    input  logic [127:0] aw_hdr_rdata,
    input  logic         ar_hdr_empty,
    output logic         ar_hdr_rden,
    input  logic [127:0] ar_hdr_rdata,
    input  logic         wdata_empty,
    output logic         wdata_rden,
    input  logic [255:0] wdata_rdata,
    input  logic         ph_ret,
    input  logic [7:0]   pd_ret,
    input  logic         nph_ret,
    output logic         tlp_valid,
    input  logic         tlp_ready,
    output logic [255:0] tlp_data,
    output logic         tlp_sop,
    output logic         tlp_eop
);
    localparam int CW = CREDIT_WIDTH;

    typedef enum logic {IDLE, DATA} state_e;

    state_e          state_q, state_d;
    logic            rr_last_q, rr_last_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]   ph_cnt_q, ph_cnt_d;
    logic [CW-1:0]   pd_cnt_q, pd_cnt_d;
    logic [CW-1:0]   nph_cnt_q, nph_cnt_d;
    logic            valid_d, sop_d, eop_d;
    logic [255:0]    data_d;

    logic [10:0]     len_dw;
    logic [7:0]      beats;
    logic [CW-1:0]   pd_need;
    logic            out_free, aw_elig, ar_elig, grant_aw, grant_ar;
    logic            ph_use, nph_use;
    logic [CW-1:0]   pd_use;

    // A zero length field encodes the maximum 1024 DW payload.
    assign len_dw  = (aw_hdr_rdata[9:0] == 10'd0) ? 11'd1024 : {1'b0, aw_hdr_rdata[9:0]};
    assign beats   = 8'((len_dw + 11'd7) >> 3);
    assign pd_need = CW'((len_dw + 11'd3) >> 2);

    assign out_free = !tlp_valid || tlp_ready;
    assign aw_elig  = !aw_hdr_empty && (ph_cnt_q != '0) && (pd_cnt_q >= pd_need);
    assign ar_elig  = !ar_hdr_empty && (nph_cnt_q != '0);
    assign grant_aw = aw_elig && (!ar_elig || rr_last_q);
    assign grant_ar = ar_elig && (!aw_elig || !rr_last_q);

    function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cnt,
                                                  input logic [CW-1:0] used,
                                                  input logic [CW-1:0] ret);
        logic [CW:0] sum;
        sum = {1'b0, cnt - used} + {1'b0, ret};
        return sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        beat_cnt_d  = beat_cnt_q;
        valid_d     = tlp_valid;
        data_d      = tlp_data;
        sop_d       = tlp_sop;
        eop_d       = tlp_eop;
        aw_hdr_rden = 1'b0;
        ar_hdr_rden = 1'b0;
        wdata_rden  = 1'b0;
        ph_use      = 1'b0;
        pd_use      = '0;
        nph_use     = 1'b0;
        if (rst_n && out_free) begin
            valid_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_aw) begin
                        aw_hdr_rden = 1'b1;
                        valid_d     = 1'b1;
                        data_d      = {128'd0, aw_hdr_rdata};
                        sop_d       = 1'b1;
                        eop_d       = 1'b0;
                        ph_use      = 1'b1;
                        pd_use      = pd_need;
                        beat_cnt_d  = beats;
                        rr_last_d   = 1'b0;
                        state_d     = DATA;
                    end else if (grant_ar) begin
                        ar_hdr_rden = 1'b1;
                        valid_d     = 1'b1;
                        data_d      = {128'd0, ar_hdr_rdata};
                        sop_d       = 1'b1;
                        eop_d       = 1'b1;
                        nph_use     = 1'b1;
                        rr_last_d   = 1'b1;
                    end
                end
                DATA: begin
                    // An empty data FIFO leaves a bubble; the link tolerates gaps inside a TLP.
                    if (!wdata_empty) begin
                        wdata_rden = 1'b1;
                        valid_d    = 1'b1;
                        data_d     = wdata_rdata;
                        sop_d      = 1'b0;
                        eop_d      = (beat_cnt_q == 8'd1);
                        beat_cnt_d = beat_cnt_q - 8'd1;
                        if (beat_cnt_q == 8'd1) begin
                            state_d = IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign ph_cnt_d  = credit_next(ph_cnt_q,  CW'(ph_use),  CW'(ph_ret));
    assign pd_cnt_d  = credit_next(pd_cnt_q,  pd_use,       CW'(pd_ret));
    assign nph_cnt_d = credit_next(nph_cnt_q, CW'(nph_use), CW'(nph_ret));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_last_q  <= 1'b1;
            beat_cnt_q <= '0;
            ph_cnt_q   <= CW'(INIT_PH);
            pd_cnt_q   <= CW'(INIT_PD);
            nph_cnt_q  <= CW'(INIT_NPH);
            tlp_valid  <= 1'b0;
            tlp_data   <= '0;
            tlp_sop    <= 1'b0;
            tlp_eop    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            beat_cnt_q <= beat_cnt_d;
            ph_cnt_q   <= ph_cnt_d;
            pd_cnt_q   <= pd_cnt_d;
            nph_cnt_q  <= nph_cnt_d;
            tlp_valid  <= valid_d;
            tlp_data   <= data_d;
            tlp_sop    <= sop_d;
            tlp_eop    <= eop_d;
        end
    end
endmodule

// File: tb/tb_tlp_tx_scheduler.sv
// tb/tb_tlp_tx_scheduler.sv - scoreboard bench for tlp_tx_scheduler with FIFO and credit models
`timescale 1ns/1ps
module tb_tlp_tx_scheduler;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         aw_hdr_empty, aw_hdr_rden, ar_hdr_empty, ar_hdr_rden, wdata_empty, wdata_rden;
    logic [127:0] aw_hdr_rdata, ar_hdr_rdata;
    logic [255:0] wdata_rdata, tlp_data;
    logic         ph_ret, nph_ret, tlp_valid, tlp_ready, tlp_sop, tlp_eop;
    logic [7:0]   pd_ret;

    tlp_tx_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .aw_hdr_empty(aw_hdr_empty), .aw_hdr_rden(aw_hdr_rden), .aw_hdr_rdata(aw_hdr_rdata),
        .ar_hdr_empty(ar_hdr_empty), .ar_hdr_rden(ar_hdr_rden), .ar_hdr_rdata(ar_hdr_rdata),
        .wdata_empty(wdata_empty), .wdata_rden(wdata_rden), .wdata_rdata(wdata_rdata),
        .ph_ret(ph_ret), .pd_ret(pd_ret), .nph_ret(nph_ret),
        .tlp_valid(tlp_valid), .tlp_ready(tlp_ready), .tlp_data(tlp_data),
        .tlp_sop(tlp_sop), .tlp_eop(tlp_eop)
    );

    always #5 clk = ~clk;

    typedef struct { logic [255:0] d; logic sop; logic eop; } beat_t;
    typedef struct { string nm; longint act; longint exp; } chk_t;

    beat_t        exp_q[$];
    chk_t         req_q[$];
    logic [127:0] aw_q[$], ar_q[$];
    logic [255:0] wd_q[$], wd_hold[$];
    int           n_cmp = 0, n_bad = 0;
    int           m_ph, m_pd, m_nph;
    int           n_ar_pops;

    function automatic logic [127:0] mk_hdr(input logic [9:0] len, input logic [31:0] tag);
        return {tag, ~tag, tag ^ 32'h5a5a_0000, 22'h0, len};
    endfunction

    task automatic refresh();
        aw_hdr_empty = (aw_q.size() == 0);
        aw_hdr_rdata = aw_hdr_empty ? '0 : aw_q[0];
        ar_hdr_empty = (ar_q.size() == 0);
        ar_hdr_rdata = ar_hdr_empty ? '0 : ar_q[0];
        wdata_empty  = (wd_q.size() == 0);
        wdata_rdata  = wdata_empty ? '0 : wd_q[0];
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        chk_t c;
        c.nm = nm; c.act = act; c.exp = exp;
        req_q.push_back(c);
    endtask

    // Inputs change 1ns after a rising edge; pops follow the rden seen just before that edge.
    task automatic step();
        logic paw, par, pwd;
        @(negedge clk); #4;
        paw = aw_hdr_rden; par = ar_hdr_rden; pwd = wdata_rden;
        @(posedge clk); #1;
        if (paw) void'(aw_q.pop_front());
        if (par) begin void'(ar_q.pop_front()); n_ar_pops++; end
        if (pwd) void'(wd_q.pop_front());
        refresh();
    endtask

    task automatic push_read(input int tag);
        beat_t b;
        logic [127:0] h;
        h = mk_hdr(10'd1, 32'(tag));
        ar_q.push_back(h);
        b.d = {128'd0, h}; b.sop = 1'b1; b.eop = 1'b1;
        exp_q.push_back(b);
        m_nph--;
        refresh();
    endtask

    task automatic push_write(input int len, input int tag, input int nd);
        int l, nb, need;
        beat_t b;
        logic [127:0] h;
        logic [255:0] d;
        l    = (len == 0) ? 1024 : len;
        nb   = (l + 7) / 8;
        need = (l + 3) / 4;
        h    = mk_hdr(10'(len), 32'(tag));
        aw_q.push_back(h);
        b.d = {128'd0, h}; b.sop = 1'b1; b.eop = 1'b0;
        exp_q.push_back(b);
        for (int i = 0; i < nb; i++) begin
            d = {8{32'(tag * 1000 + i)}};
            if (i < nd) wd_q.push_back(d); else wd_hold.push_back(d);
            b.d = d; b.sop = 1'b0; b.eop = (i == nb - 1);
            exp_q.push_back(b);
        end
        m_ph--;
        m_pd -= need;
        refresh();
    endtask

    task automatic release_data(input int n);
        for (int i = 0; i < n; i++) wd_q.push_back(wd_hold.pop_front());
        refresh();
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || aw_q.size() != 0 || ar_q.size() != 0 || wd_q.size() != 0) && t < 3000) begin
            step();
            t++;
        end
        step(); step();
        if (t >= 3000) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic chk_credits(input string nm);
        chk({nm, "_ph"},  longint'(dut.ph_cnt_q),  m_ph);
        chk({nm, "_pd"},  longint'(dut.pd_cnt_q),  m_pd);
        chk({nm, "_nph"}, longint'(dut.nph_cnt_q), m_nph);
    endtask

    task automatic model_reset();
        m_ph = 32; m_pd = 256; m_nph = 32;
    endtask

    // Single compare process: scoreboard beats, hold stability, reset rden, queued literal checks.
    logic         hold_v = 1'b0;
    logic [255:0] hold_d;
    logic         hold_s, hold_e;
    always @(negedge clk) begin
        chk_t  c;
        beat_t e;
        while (req_q.size() != 0) begin
            c = req_q.pop_front();
            n_cmp++;
            if (c.act != c.exp) begin
                n_bad++;
                $display("FAIL %s: got %0d want %0d", c.nm, c.act, c.exp);
            end
        end
        if (!rst_n) begin
            n_cmp++;
            if (aw_hdr_rden || ar_hdr_rden || wdata_rden) begin
                n_bad++;
                $display("FAIL rden_in_reset: got %b%b%b want 000", aw_hdr_rden, ar_hdr_rden, wdata_rden);
            end
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                n_cmp++;
                if (!tlp_valid || tlp_data != hold_d || tlp_sop != hold_s || tlp_eop != hold_e) begin
                    n_bad++;
                    $display("FAIL hold: got v=%b sop=%b eop=%b d=%h want v=1 sop=%b eop=%b d=%h",
                             tlp_valid, tlp_sop, tlp_eop, tlp_data, hold_s, hold_e, hold_d);
                end
            end
            if (tlp_valid && tlp_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL beat: got unexpected d=%h sop=%b eop=%b want none", tlp_data, tlp_sop, tlp_eop);
                end else begin
                    e = exp_q.pop_front();
                    if (tlp_data != e.d || tlp_sop != e.sop || tlp_eop != e.eop) begin
                        n_bad++;
                        $display("FAIL beat: got d=%h sop=%b eop=%b want d=%h sop=%b eop=%b",
                                 tlp_data, tlp_sop, tlp_eop, e.d, e.sop, e.eop);
                    end
                end
            end
            hold_v = tlp_valid && !tlp_ready;
            hold_d = tlp_data; hold_s = tlp_sop; hold_e = tlp_eop;
        end
    end

    initial begin
        int bubbles, t;
        rst_n = 1'b0; tlp_ready = 1'b1; ph_ret = 1'b0; pd_ret = 8'd0; nph_ret = 1'b0;
        refresh();
        model_reset();
        step(); step(); step();
        chk("rst_valid", tlp_valid, 0);
        chk("rst_sop", tlp_sop, 0);
        chk("rst_eop", tlp_eop, 0);
        chk("rst_data", (tlp_data != '0), 0);
        chk("rst_ph", longint'(dut.ph_cnt_q), 32);
        chk("rst_pd", longint'(dut.pd_cnt_q), 256);
        chk("rst_nph", longint'(dut.nph_cnt_q), 32);
        rst_n = 1'b1;
        step();

        n_ar_pops = 0;
        push_read(11);
        step();
        chk("read_valid_n1", tlp_valid, 1);
        chk("read_sop", tlp_sop, 1);
        chk("read_eop", tlp_eop, 1);
        drain("read");
        chk("read_pops", n_ar_pops, 1);
        chk("read_nph", longint'(dut.nph_cnt_q), 31);
        chk_credits("read");

        push_write(16, 21, 2);
        drain("write16");
        chk("write16_ph", longint'(dut.ph_cnt_q), 31);
        chk("write16_pd", longint'(dut.pd_cnt_q), 252);
        chk_credits("write16");

        rst_n = 1'b0; step(); rst_n = 1'b1; model_reset();
        push_write(8, 31, 1); push_read(32); push_write(8, 33, 1); push_read(34);
        drain("alternate");
        chk_credits("alternate");

        push_write(24, 41, 1);
        bubbles = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!tlp_valid) bubbles++;
        end
        chk("bubble_seen", (bubbles > 0), 1);
        release_data(2);
        tlp_ready = 1'b0;
        step(); step(); step();
        chk("stall_valid", tlp_valid, 1);
        chk("stall_eop", tlp_eop, 0);
        chk("stall_no_extra_pop", wd_q.size(), 1);
        tlp_ready = 1'b1;
        drain("stall");
        chk_credits("stall");

        push_write(64, 51, 3);
        t = 0;
        while (exp_q.size() > 5 && t < 50) begin step(); t++; end
        if (t >= 50) chk("midtlp_timeout", 0, 1);
        rst_n = 1'b0;
        step();
        chk("midrst_valid", tlp_valid, 0);
        chk("midrst_sop", tlp_sop, 0);
        chk("midrst_eop", tlp_eop, 0);
        chk("midrst_data", (tlp_data != '0), 0);
        chk("midrst_ph", longint'(dut.ph_cnt_q), 32);
        chk("midrst_pd", longint'(dut.pd_cnt_q), 256);
        chk("midrst_nph", longint'(dut.nph_cnt_q), 32);
        exp_q.delete(); wd_hold.delete(); wd_q.delete(); refresh();
        model_reset();
        push_read(52);
        step(); step();
        chk("ar_held_in_reset", ar_q.size(), 1);
        rst_n = 1'b1;
        drain("post_reset");
        chk_credits("post_reset");

        push_write(0, 61, 128);
        drain("len0");
        chk("len0_pd", longint'(dut.pd_cnt_q), 0);
        chk_credits("len0");

        push_read(71);
        drain("pre_block");
        pd_ret = 8'd3; nph_ret = 1'b1; m_pd += 3; m_nph++;
        step();
        pd_ret = 8'd0; nph_ret = 1'b0;
        push_read(72);
        push_write(16, 73, 2);
        for (int i = 0; i < 8; i++) step();
        chk("aw_blocked", aw_q.size(), 1);
        chk("aw_blocked_exp", exp_q.size(), 3);
        chk("block_pd", longint'(dut.pd_cnt_q), 3);
        pd_ret = 8'd1; m_pd += 1;
        step();
        pd_ret = 8'd0;
        drain("unblock");
        chk("unblock_pd", longint'(dut.pd_cnt_q), 0);
        chk_credits("unblock");

        chk("exp_left", exp_q.size(), 0);
        step(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tlp_tx_scheduler.md
# tlp_tx_scheduler

Transmit-side scheduler that merges the AW and AR request-header FIFOs and the write-data FIFO into one 256-bit TLP stream toward the PCIe link layer. It grants one request at a time by round-robin, gates each grant on flow-control credits (PH/PD for memory writes, NPH for reads), and streams a write TLP's payload beats behind its header. It sits between the header/data FIFOs written by the AXI-side header makers and the TX link interface.

## Interface

- CREDIT_WIDTH, 12: width of each credit counter.
- INIT_PH, 32: posted-header credits after reset.
- INIT_PD, 256: posted-data credits after reset (1 credit = 4 DW).
- INIT_NPH, 32: non-posted-header credits after reset.

- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- aw_hdr_empty  in  1  write-header FIFO empty (FWFT FIFO).
- aw_hdr_rden  out  1  pop write-header FIFO.
- aw_hdr_rdata  in  128  write TLP header; DW0 in [31:0], length field = [9:0].
- ar_hdr_empty  in  1  read-header FIFO empty (FWFT FIFO).
- ar_hdr_rden  out  1  pop read-header FIFO.
- ar_hdr_rdata  in  128  read TLP header.
- wdata_empty  in  1  write-data FIFO empty (FWFT FIFO).
- wdata_rden  out  1  pop write-data FIFO.
- wdata_rdata  in  256  payload beat (8 DW).
- ph_ret  in  1  one PH credit returned this cycle.
- pd_ret  in  8  number of PD credits returned this cycle.
- nph_ret  in  1  one NPH credit returned this cycle.
- tlp_valid  out  1  output beat valid.
- tlp_ready  in  1  link layer accepts beat.
- tlp_data  out  256  beat; header beats carry header in [127:0], zeros in [255:128].
- tlp_sop  out  1  first beat of TLP.
- tlp_eop  out  1  last beat of TLP.

## Operation

- FIFOs are first-word-fall-through: rdata valid whenever !empty; rden pops. rden outputs are combinational and asserted only when that entry is loaded into the output register.
- Output register: tlp_valid/data/sop/eop are registered. out_free = !tlp_valid || tlp_ready. New beat loads only when out_free; otherwise all outputs hold.
- Length decode: len_dw = hdr[9:0], 0 means 1024. beats = ceil(len_dw/8) (1..128, 8-bit counter). pd_need = ceil(len_dw/4) (1..256).
- Eligibility: AW eligible = !aw_hdr_empty && ph_cnt>=1 && pd_cnt>=pd_need. AR eligible = !ar_hdr_empty && nph_cnt>=1.
- Arbitration: rr_last (0=AW, 1=AR), reset to 1. If both eligible, grant the one != rr_last; else grant the eligible one. rr_last <= granted source.
- FSM states IDLE, DATA.
  - IDLE, out_free, grant AW: pop AW header, load header beat (sop=1, eop=0), ph_cnt -= 1, pd_cnt -= pd_need, beat_cnt <= beats, go DATA.
  - IDLE, out_free, grant AR: pop AR header, load header beat (sop=1, eop=1), nph_cnt -= 1, stay IDLE.
  - IDLE, no grant or !out_free: if out_free, tlp_valid <= 0.
  - DATA, out_free, !wdata_empty: pop beat, load (sop=0, eop = beat_cnt==1), beat_cnt -= 1; after last beat go IDLE.
  - DATA, out_free, wdata_empty: tlp_valid <= 0 (bubble allowed; link tolerates gaps inside TLP). No arbitration in DATA.
- Credits: cnt_next = cnt - consumed + returned, same-cycle consume and return both apply; saturate at 2^CREDIT_WIDTH-1. Eligibility uses registered counts (returns visible next cycle).
- Reset (rst_n low at a clock edge, including mid-TLP): state IDLE, tlp_valid/sop/eop 0, tlp_data 0, beat_cnt 0, rr_last 1, ph_cnt=INIT_PH, pd_cnt=INIT_PD, nph_cnt=INIT_NPH. All rden 0 while rst_n low. A partially sent TLP is abandoned; no recovery.

## Timing

- Header popped in cycle N -> tlp_valid high at N+1.
- Back-to-back: with tlp_ready held 1, one beat per cycle; a read header may follow a write's eop beat in the next cycle.
- Write TLP of B beats occupies B+1 output beats minimum.
- Credits debited in the grant cycle, visible at N+1.
- tlp_data/sop/eop stable while tlp_valid && !tlp_ready.

## Test plan

- Single read: AR header len=1, tlp_ready=1 -> one beat, sop=eop=1, data[127:0]=header, nph_cnt 32->31, ar_hdr_rden one cycle.
- Write len_dw=16 with 2 data beats queued -> 3 beats (sop on header, eop on beat 2), ph 32->31, pd 256->252.
- Both FIFOs continuously non-empty, ample credits -> grants alternate AW, AR, AW, …, AW first after reset.
- pd_cnt=3, AW header len_dw=16, AR pending -> AR granted, AW blocked; pd_ret=1 -> AW granted next IDLE decision.
- tlp_ready low 3 cycles mid-write plus wdata_empty gap -> outputs held stable, bubble with tlp_valid=0, no beat lost/duplicated; len_dw=0 -> 128 data beats, pd -256.
- Assert rst_n=0 during DATA beat 3 of 8 -> next edge: tlp_valid=0, IDLE, credits back to INIT values, no rden while in reset.
